// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the single-port data memory between the pipeline MEM
//               stage (priority) and an external valid/ready master, with a
//               starvation counter that forces one external access.
// Revision    : 1.0
// ============================================================================
module dmem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_valid,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ready,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [0:0] CPU_OWN   = 1'b0;
  localparam logic [0:0] EXT_FORCE = 1'b1;

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(STARVE_MAX - 1);
  localparam logic [CNT_W-1:0] c_cnt_sat  = {CNT_W{1'b1}};

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ext_rvalid;
  logic [DATA_W-1:0] r_ext_rdata;

  logic w_cpu_req;
  logic w_grant_ext;
  logic w_cpu_stall;
  logic w_denied;
  logic w_ext_read;

  assign w_cpu_req  = cpu_rd | cpu_wr;
  assign w_denied   = ext_valid & ~w_grant_ext;
  assign w_ext_read = w_grant_ext & ~ext_we;

  // Stall only depends on state and request inputs, never on memory data.
  always_comb begin
    w_grant_ext = ext_valid & ~w_cpu_req;
    w_cpu_stall = 1'b0;
    if (r_state == EXT_FORCE) begin
      w_grant_ext = ext_valid;
      w_cpu_stall = w_cpu_req & ext_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= CPU_OWN;
      r_cnt   <= '0;
    end else if (r_state == EXT_FORCE) begin
      r_state <= CPU_OWN;
      r_cnt   <= '0;
    end else if (w_denied) begin
      if (r_cnt == c_cnt_last) begin
        r_state <= EXT_FORCE;
        r_cnt   <= '0;
      end else if (r_cnt != c_cnt_sat) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ext_rvalid <= 1'b0;
      r_ext_rdata  <= '0;
    end else begin
      r_ext_rvalid <= w_ext_read;
      if (w_ext_read) begin
        r_ext_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_rd    = cpu_rd & ~w_cpu_stall;
    mem_wr    = cpu_wr & ~w_cpu_stall;
    if (w_grant_ext) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_rd    = ~ext_we;
      mem_wr    = ext_we;
    end
  end

  assign cpu_rdata  = mem_rdata;
  assign cpu_stall  = w_cpu_stall;
  assign ext_ready  = w_grant_ext;
  assign ext_rvalid = r_ext_rvalid;
  assign ext_rdata  = r_ext_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed plus randomized bench for dmem_port_arbiter with a
//               behavioural memory/arbitration reference model.
// Revision    : 1.0
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_valid, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_ready, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .CNT_W(3)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_valid(ext_valid), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_ready(ext_ready), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input int i);
    return 32'h5A00_0000 + (i * 32'h0001_0003);
  endfunction

  // Memory the arbiter drives: combinational read, write on posedge.
  logic [31:0] tb_mem [0:255];
  logic        init_mem;
  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= pattern(i);
    end else if (mem_wr) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          streak;
  bit          forced;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;
  bit          m_grant;

  int checks;
  int failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic ev, input logic ewe, input logic [31:0] ea, input logic [31:0] ed,
                       input string tag);
    bit req, grant, stall, xrd, xwr;
    logic [31:0] xaddr, xdata;
    cpu_rd = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_valid = ev; ext_we = ewe; ext_addr = ea; ext_wdata = ed;
    #1;
    req = cr | cw;
    if (forced) begin
      grant = ev;
      stall = req & ev;
    end else begin
      grant = ev & !req;
      stall = 1'b0;
    end
    m_grant = grant;
    if (grant) begin
      xrd = !ewe; xwr = ewe; xaddr = ea; xdata = ed;
    end else begin
      xrd = cr & !stall; xwr = cw & !stall; xaddr = ca; xdata = cd;
    end
    chk({tag, ".ext_ready"}, {31'b0, ext_ready}, {31'b0, grant});
    chk({tag, ".cpu_stall"}, {31'b0, cpu_stall}, {31'b0, stall});
    chk({tag, ".mem_rd"}, {31'b0, mem_rd}, {31'b0, xrd});
    chk({tag, ".mem_wr"}, {31'b0, mem_wr}, {31'b0, xwr});
    chk({tag, ".mem_addr"}, mem_addr, xaddr);
    if (xwr) chk({tag, ".mem_wdata"}, mem_wdata, xdata);
    if (!grant && xrd) chk({tag, ".cpu_rdata"}, cpu_rdata, ref_mem[ca[7:0]]);
    @(posedge clk);
    #1;
    if (grant && !ewe) begin
      exp_rvalid = 1'b1;
      exp_rdata  = ref_mem[ea[7:0]];
    end else begin
      exp_rvalid = 1'b0;
    end
    if (xwr) ref_mem[xaddr[7:0]] = xdata;
    // Count consecutive denied cycles; the STARVE_MAX-th forces one grant.
    if (forced) begin
      forced = 0;
      streak = 0;
    end else if (ev && !grant) begin
      streak++;
      if (streak == STARVE_MAX) begin
        forced = 1;
        streak = 0;
      end
    end else begin
      streak = 0;
    end
    chk({tag, ".ext_rvalid"}, {31'b0, ext_rvalid}, {31'b0, exp_rvalid});
    chk({tag, ".ext_rdata"}, ext_rdata, exp_rdata);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          pend_v, pend_we;
    logic [31:0] pend_a, pend_d;
    int          r;
    logic        rc_rd, rc_wr;

    checks = 0; failures = 0;
    streak = 0; forced = 0; exp_rvalid = 1'b0; exp_rdata = '0; m_grant = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pattern(i);

    // Reset state
    reset = 1'b1; init_mem = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_valid = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    @(posedge clk); #1;
    chk("rst.cpu_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rst.ext_rvalid", {31'b0, ext_rvalid}, 32'd0);
    chk("rst.ext_rdata", ext_rdata, 32'd0);
    chk("rst.ext_ready_idle", {31'b0, ext_ready}, 32'd0);
    @(negedge clk);
    ext_valid = 1'b1;
    #1;
    chk("rst.ext_ready_req", {31'b0, ext_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rst.ext_rvalid_held", {31'b0, ext_rvalid}, 32'd0);
    @(negedge clk);
    reset = 1'b0; init_mem = 1'b0; ext_valid = 1'b0;

    // CPU only
    cycle(0, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, "cpu_wr");
    cycle(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, "cpu_rd");
    chk("cpu_rd.value", ref_mem[8'h10], 32'hDEADBEEF);

    // Ext only
    cycle(0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, "ext_wr");
    cycle(0, 0, 0, 0, 1, 0, 32'h20, 32'h0, "ext_rd");
    chk("ext_rd.value", ext_rdata, 32'h12345678);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "ext_idle");

    // Collision: CPU wins twice, then ext gets the idle slot
    cycle(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, "coll1");
    cycle(1, 0, 32'h10, 0, 1, 0, 32'h20, 0, "coll2");
    cycle(0, 0, 32'h10, 0, 1, 0, 32'h20, 0, "coll3");
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "coll_idle");

    // Starvation
    cycle(0, 1, 32'h40, 32'hCAFEF00D, 0, 0, 0, 0, "st_seed");
    for (int i = 0; i < 5; i++) cycle(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, "starve");
    cycle(1, 0, 32'h10, 0, 0, 0, 0, 0, "st_after");
    chk("st_after.value", ext_rdata, 32'hCAFEF00D);

    // Asynchronous reset during the forced cycle
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'h10, 0, 1, 0, 32'h40, 0, "rm_deny");
    cpu_rd = 1; cpu_wr = 0; cpu_addr = 32'h10; ext_valid = 1; ext_we = 0; ext_addr = 32'h40;
    #1;
    chk("rm.force_stall", {31'b0, cpu_stall}, 32'd1);
    chk("rm.force_ready", {31'b0, ext_ready}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rm.async_stall", {31'b0, cpu_stall}, 32'd0);
    chk("rm.async_ready", {31'b0, ext_ready}, 32'd0);
    @(posedge clk); #1;
    chk("rm.rvalid", {31'b0, ext_rvalid}, 32'd0);
    chk("rm.rdata", ext_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    forced = 0; streak = 0; exp_rvalid = 1'b0; exp_rdata = '0;
    cycle(1, 0, 32'h10, 0, 0, 0, 0, 0, "post_rst");

    // Protocol violation: ext_valid drops in the forced cycle
    for (int i = 0; i < 4; i++) cycle(1, 0, 32'h10, 0, 1, 1, 32'h44, 32'h55, "pv_deny");
    cycle(1, 0, 32'h10, 0, 0, 0, 0, 0, "pv_drop");
    cycle(1, 0, 32'h10, 0, 1, 1, 32'h44, 32'h55, "pv_after");
    cycle(1, 0, 32'h44, 0, 0, 0, 0, 0, "pv_check");

    // Randomized traffic
    pend_v = 0; pend_we = 0; pend_a = '0; pend_d = '0;
    for (int n = 0; n < 300; n++) begin
      if (!pend_v && ($urandom_range(0, 1) == 1)) begin
        pend_v  = 1;
        pend_we = $urandom_range(0, 1) == 1;
        pend_a  = 32'($urandom_range(0, 255));
        pend_d  = $urandom;
      end
      r = $urandom_range(0, 9);
      rc_rd = (r >= 3 && r <= 6);
      rc_wr = (r >= 7);
      cycle(rc_rd, rc_wr, 32'($urandom_range(0, 255)), $urandom,
            pend_v, pend_we, pend_a, pend_d, "rand");
      if (m_grant) pend_v = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
